// File: rtl/mempool_refill_server_if.sv
// Refill request/response and L2 memory handshake bundle for mempool_refill_server.
// The slave modport is the refill server's view; master is the tile + L2 side.
interface mempool_refill_server_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LineWidth = 128,
    parameter int unsigned LenWidth  = 3
) ();
    logic                 refill_qvalid_i;
    logic                 refill_qready_o;
    logic [AddrWidth-1:0] refill_qaddr_i;
    logic [LenWidth-1:0]  refill_qlen_i;
    logic [LineWidth-1:0] refill_pdata_o;
    logic                 refill_pvalid_o;
    logic                 refill_plast_o;
    logic                 refill_pready_i;
    logic                 mem_req_o;
    logic                 mem_gnt_i;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0] mem_rdata_i;
    logic                 mem_rvalid_i;
    logic                 busy_o;

    modport slave (
        input  refill_qvalid_i, refill_qaddr_i, refill_qlen_i, refill_pready_i,
        input  mem_gnt_i, mem_rdata_i, mem_rvalid_i,
        output refill_qready_o, refill_pdata_o, refill_pvalid_o, refill_plast_o,
        output mem_req_o, mem_addr_o, busy_o
    );

    modport master (
        output refill_qvalid_i, refill_qaddr_i, refill_qlen_i, refill_pready_i,
        output mem_gnt_i, mem_rdata_i, mem_rvalid_i,
        input  refill_qready_o, refill_pdata_o, refill_pvalid_o, refill_plast_o,
        input  mem_req_o, mem_addr_o, busy_o
    );
endinterface

// File: rtl/mempool_refill_server.sv
// Instruction-refill responder for one MemPool tile: fetches each requested
// cache line word-by-word from L2, assembles it, and returns it to the tile.
module mempool_refill_server #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LineWidth = 128,
    parameter int unsigned LenWidth  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    mempool_refill_server_if.slave  bus_if
);
    localparam int unsigned BeWidth      = DataWidth / 8;
    localparam int unsigned WordsPerLine = LineWidth / DataWidth;
    localparam int unsigned IdxWidth     = $clog2(WordsPerLine);
    localparam int unsigned CntWidth     = IdxWidth + 1;

    localparam logic [AddrWidth-1:0] LineBytes = AddrWidth'(LineWidth / 8);
    localparam logic [AddrWidth-1:0] WordBytes = AddrWidth'(BeWidth);
    localparam logic [CntWidth-1:0]  LastWord  = CntWidth'(WordsPerLine - 1);
    localparam logic [CntWidth-1:0]  FullCnt   = CntWidth'(WordsPerLine);

    typedef enum logic [1:0] {Idle, Fetch, Resp} state_e;

    state_e                              state_q;
    logic [AddrWidth-1:0]                line_addr_q;
    logic [LenWidth-1:0]                 lines_left_q;
    logic [CntWidth-1:0]                 req_cnt_q;
    logic [CntWidth-1:0]                 rsp_cnt_q;
    logic [WordsPerLine-1:0][DataWidth-1:0] line_buf_q;
    logic                                qready_q;
    logic                                pvalid_q;
    logic                                plast_q;
    logic                                mem_req_q;
    logic [AddrWidth-1:0]                mem_addr_q;

    logic [CntWidth-1:0]  req_next_d;
    logic [AddrWidth-1:0] req_addr_d;
    logic [AddrWidth-1:0] next_line_d;
    logic [AddrWidth-1:0] start_line_d;
    logic                 req_fire_d;
    logic                 rsp_take_d;

    // Next-address arithmetic and handshake qualifiers shared by the FSM.
    // A read beat is only taken while words are outstanding, so beats that
    // belong to an abandoned burst are silently dropped.
    always_comb begin
        req_next_d   = req_cnt_q + CntWidth'(1);
        req_addr_d   = line_addr_q + AddrWidth'(req_next_d) * WordBytes;
        next_line_d  = line_addr_q + LineBytes;
        start_line_d = bus_if.refill_qaddr_i & ~(LineBytes - AddrWidth'(1));
        req_fire_d   = mem_req_q && bus_if.mem_gnt_i;
        rsp_take_d   = (state_q == Fetch) && bus_if.mem_rvalid_i && (rsp_cnt_q != req_cnt_q);
    end

    // Refill FSM with registered outputs: accept a burst, fetch one line,
    // present it until taken, then fetch the next line or return to idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= Idle;
            line_addr_q  <= '0;
            lines_left_q <= '0;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            line_buf_q   <= '0;
            qready_q     <= 1'b1;
            pvalid_q     <= 1'b0;
            plast_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            case (state_q)
                Idle: begin
                    if (bus_if.refill_qvalid_i && qready_q) begin
                        line_addr_q  <= start_line_d;
                        lines_left_q <= bus_if.refill_qlen_i;
                        req_cnt_q    <= '0;
                        rsp_cnt_q    <= '0;
                        qready_q     <= 1'b0;
                        mem_req_q    <= 1'b1;
                        mem_addr_q   <= start_line_d;
                        state_q      <= Fetch;
                    end
                end
                Fetch: begin
                    if (req_fire_d) begin
                        req_cnt_q <= req_next_d;
                        if (req_next_d == FullCnt) begin
                            mem_req_q <= 1'b0;
                        end else begin
                            mem_addr_q <= req_addr_d;
                        end
                    end
                    if (rsp_take_d) begin
                        line_buf_q[rsp_cnt_q[IdxWidth-1:0]] <= bus_if.mem_rdata_i;
                        rsp_cnt_q <= rsp_cnt_q + CntWidth'(1);
                        if (rsp_cnt_q == LastWord) begin
                            pvalid_q <= 1'b1;
                            plast_q  <= (lines_left_q == '0);
                            state_q  <= Resp;
                        end
                    end
                end
                Resp: begin
                    if (bus_if.refill_pready_i) begin
                        pvalid_q <= 1'b0;
                        plast_q  <= 1'b0;
                        if (plast_q) begin
                            qready_q <= 1'b1;
                            state_q  <= Idle;
                        end else begin
                            line_addr_q  <= next_line_d;
                            lines_left_q <= lines_left_q - LenWidth'(1);
                            req_cnt_q    <= '0;
                            rsp_cnt_q    <= '0;
                            mem_req_q    <= 1'b1;
                            mem_addr_q   <= next_line_d;
                            state_q      <= Fetch;
                        end
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

    assign bus_if.refill_qready_o = qready_q;
    assign bus_if.refill_pvalid_o = pvalid_q;
    assign bus_if.refill_plast_o  = plast_q;
    assign bus_if.refill_pdata_o  = pvalid_q ? line_buf_q : '0;
    assign bus_if.mem_req_o       = mem_req_q;
    assign bus_if.mem_addr_o      = mem_addr_q;
    assign bus_if.busy_o          = (state_q != Idle);
endmodule

// File: tb/tb_mempool_refill_server.sv
// Scoreboard bench for mempool_refill_server: an L2 model returns word = address,
// expected lines are queued at request time and checked by a separate monitor.
module tb_mempool_refill_server;
    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;
    int   cyc;

    bit   gntRandom;
    bit   readyRandom;
    int   latMin;
    int   latMax;

    exp_t        expQ[$];
    logic [31:0] pendAddr[$];
    int          pendDue[$];

    mempool_refill_server_if bus ();

    mempool_refill_server dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    // Free-running clock and cycle counter used by the memory latency model.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Compare one value and record the result.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Line contents the L2 model produces: each word equals its own byte address.
    function automatic logic [127:0] lineFor(input logic [31:0] a);
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    // L2 model: grants requests (always or randomly) and returns data in order
    // after a programmable latency of at least one cycle.
    initial begin
        int lastDue;
        int due;
        lastDue = 0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            bus.mem_gnt_i = gntRandom ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.mem_gnt_i && bus.mem_req_o && !rst) begin
                due = cyc + int'($urandom_range(latMin, latMax));
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                pendAddr.push_back(bus.mem_addr_o);
                pendDue.push_back(due);
            end
            if (pendDue.size() > 0 && pendDue[0] <= cyc) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = pendAddr.pop_front();
                void'(pendDue.pop_front());
            end else begin
                bus.mem_rvalid_i = 1'b0;
                bus.mem_rdata_i  = '0;
            end
        end
    end

    // Tile response back-pressure driver.
    initial begin
        bus.refill_pready_i = 1'b1;
        forever begin
            @(negedge clk);
            bus.refill_pready_i = readyRandom ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    // Monitor: checks every accepted beat against the scoreboard and checks
    // that stalled responses and ungranted memory requests hold steady.
    initial begin
        exp_t         e;
        bit           stallP;
        bit           stallM;
        logic [127:0] prevP;
        logic [31:0]  prevA;
        stallP = 0;
        stallM = 0;
        prevP  = '0;
        prevA  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stallP = 0;
                stallM = 0;
            end else begin
                if (stallP) begin
                    checkOutput("pvalid_hold", 128'(bus.refill_pvalid_o), 128'd1);
                    checkOutput("pdata_hold", bus.refill_pdata_o, prevP);
                end
                if (stallM) begin
                    checkOutput("mem_req_hold", 128'(bus.mem_req_o), 128'd1);
                    checkOutput("mem_addr_hold", 128'(bus.mem_addr_o), 128'(prevA));
                end
                stallP = bus.refill_pvalid_o && !bus.refill_pready_i;
                prevP  = bus.refill_pdata_o;
                stallM = bus.mem_req_o && !bus.mem_gnt_i;
                prevA  = bus.mem_addr_o;
                if (bus.refill_pvalid_o && bus.refill_pready_i) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unexpected_beat: got pdata %h expected no beat", bus.refill_pdata_o);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beat_data", bus.refill_pdata_o, e.data);
                        checkOutput("beat_last", 128'(bus.refill_plast_o), 128'(e.last));
                    end
                end
            end
        end
    end

    // Queue the expected lines of a burst and hand the request to the DUT.
    // Returns on the falling edge right after the accepting clock edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] len);
        logic [31:0] base;
        exp_t        e;
        int          n;
        base = addr & 32'hFFFF_FFF0;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = lineFor(base + 32'(i * 16));
            e.last = (i == int'(len));
            expQ.push_back(e);
        end
        @(negedge clk);
        bus.refill_qvalid_i = 1'b1;
        bus.refill_qaddr_i  = addr;
        bus.refill_qlen_i   = len;
        #1;
        n = 0;
        while (!bus.refill_qready_o && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        nChecks++;
        if (n >= 200) begin
            nFails++;
            $display("[TB] FAIL req_accept: got qready 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        bus.refill_qvalid_i = 1'b0;
    endtask

    // Wait for all expected beats to drain, then check the DUT is idle again.
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        #1;
        while ((expQ.size() != 0 || bus.refill_pvalid_o) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        nChecks++;
        if (n >= 500) begin
            nFails++;
            $display("[TB] FAIL %s_drain: got %0d beats pending expected 0", name, expQ.size());
        end
        @(negedge clk);
        #1;
        checkOutput({name, "_idle_qready"}, 128'(bus.refill_qready_o), 128'd1);
        checkOutput({name, "_idle_busy"}, 128'(bus.busy_o), 128'd0);
    endtask

    // Directed scenarios.
    initial begin
        int c;
        nChecks     = 0;
        nFails      = 0;
        gntRandom   = 0;
        readyRandom = 0;
        latMin      = 1;
        latMax      = 1;
        rst         = 1'b1;
        bus.refill_qvalid_i = 1'b0;
        bus.refill_qaddr_i  = '0;
        bus.refill_qlen_i   = '0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_qready", 128'(bus.refill_qready_o), 128'd1);
        checkOutput("rst_pvalid", 128'(bus.refill_pvalid_o), 128'd0);
        checkOutput("rst_plast", 128'(bus.refill_plast_o), 128'd0);
        checkOutput("rst_pdata", bus.refill_pdata_o, 128'd0);
        checkOutput("rst_mem_req", 128'(bus.mem_req_o), 128'd0);
        checkOutput("rst_mem_addr", 128'(bus.mem_addr_o), 128'd0);
        checkOutput("rst_busy", 128'(bus.busy_o), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single line with fixed latency");
        applyStimulus(32'h8001_0000, 3'd0);
        c = 0;
        #1;
        while (!bus.refill_pvalid_o && c < 50) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            #1;
        end
        checkOutput("s1_pvalid_latency", 128'(c), 128'd5);
        checkOutput("s1_first_line", bus.refill_pdata_o, 128'h8001000C_80010008_80010004_80010000);
        waitDrain("s1");

        $display("[TB] four-line burst");
        applyStimulus(32'h8001_0040, 3'd3);
        waitDrain("s2");

        $display("[TB] four-line burst with random grant, latency and stalls");
        gntRandom   = 1;
        readyRandom = 1;
        latMin      = 1;
        latMax      = 4;
        applyStimulus(32'h8001_0040, 3'd3);
        waitDrain("s3");
        gntRandom   = 0;
        readyRandom = 0;
        latMin      = 1;
        latMax      = 1;

        $display("[TB] unaligned request address");
        applyStimulus(32'h8001_0046, 3'd0);
        waitDrain("s4");

        $display("[TB] address wrap at top of memory");
        applyStimulus(32'hFFFF_FFF0, 3'd1);
        waitDrain("s5");

        $display("[TB] reset during fetch with late read beats");
        latMin = 4;
        latMax = 4;
        applyStimulus(32'h8001_0000, 3'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        expQ.delete();
        repeat (8) @(negedge clk);
        #1;
        checkOutput("s6_qready", 128'(bus.refill_qready_o), 128'd1);
        checkOutput("s6_pvalid", 128'(bus.refill_pvalid_o), 128'd0);
        checkOutput("s6_pdata", bus.refill_pdata_o, 128'd0);
        checkOutput("s6_mem_req", 128'(bus.mem_req_o), 128'd0);
        checkOutput("s6_busy", 128'(bus.busy_o), 128'd0);
        latMin = 1;
        latMax = 1;
        applyStimulus(32'h8001_0080, 3'd0);
        waitDrain("s6");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got simulation still running expected completion");
        $fatal(1, "[TB] timeout");
    end
endmodule
